// File: rtl/alu_control_if.sv
// ALU control bus: decode inputs and registered results.
// The master drives operands; the slave (the ALU) returns results.
interface alu_control_if;
    logic [3:0]  func_code;
    logic [6:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  alu_ctl;
    logic [31:0] alu_out;
    logic        branch_enable;

    modport master (
        output func_code, opcode, a, b,
        input  alu_ctl, alu_out, branch_enable
    );

    modport slave (
        input  func_code, opcode, a, b,
        output alu_ctl, alu_out, branch_enable
    );
endinterface

// File: rtl/alu_control.sv
// RV32I ALU with instruction decode and branch compare.
// Decode, compute and compare are combinational; results are registered.
module alu_control (
    input  logic          clk,
    input  logic          reset,
    alu_control_if.slave  bus
);
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SRL   = 4'b0011;
    localparam logic [3:0] OP_SRA   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_PASSB = 4'b1010;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;
    localparam logic [2:0] BR_BLTU = 3'b101;
    localparam logic [2:0] BR_BGEU = 3'b110;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [3:0]  op;
    logic [2:0]  br;
    logic [31:0] res;
    logic        taken;
    logic        eq, lt, ltu;
    logic [4:0]  shamt;

    logic [6:0]  alu_ctl_q, alu_ctl_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic        br_en_q, br_en_d;

    assign eq    = (bus.a == bus.b);
    assign lt    = ($signed(bus.a) < $signed(bus.b));
    assign ltu   = (bus.a < bus.b);
    assign shamt = bus.b[4:0];

    // Decode opcode/func_code into operation and branch condition.
    always_comb begin
        op = OP_ADD;
        br = BR_NONE;
        unique case (bus.opcode)
            OPC_R: begin
                unique case (bus.func_code)
                    4'b0000: op = OP_ADD;
                    4'b1000: op = OP_SUB;
                    4'b0001: op = OP_SLL;
                    4'b0010: op = OP_SLT;
                    4'b0011: op = OP_SLTU;
                    4'b0100: op = OP_XOR;
                    4'b0101: op = OP_SRL;
                    4'b1101: op = OP_SRA;
                    4'b0110: op = OP_OR;
                    4'b0111: op = OP_AND;
                    default: op = OP_ADD;
                endcase
            end
            OPC_I: begin
                unique case (bus.func_code[2:0])
                    3'b000: op = OP_ADD;
                    3'b001: op = OP_SLL;
                    3'b010: op = OP_SLT;
                    3'b011: op = OP_SLTU;
                    3'b100: op = OP_XOR;
                    3'b101: op = bus.func_code[3] ? OP_SRA : OP_SRL;
                    3'b110: op = OP_OR;
                    default: op = OP_AND;
                endcase
            end
            OPC_LUI: op = OP_PASSB;
            OPC_BRANCH: begin
                op = OP_SUB;
                unique case (bus.func_code[2:0])
                    3'b000: br = BR_BEQ;
                    3'b001: br = BR_BNE;
                    3'b100: br = BR_BLT;
                    3'b101: br = BR_BGE;
                    3'b110: br = BR_BLTU;
                    3'b111: br = BR_BGEU;
                    default: br = BR_NONE;
                endcase
            end
            default: op = OP_ADD;
        endcase
    end

    // Compute the ALU result for the decoded operation.
    always_comb begin
        res = 32'd0;
        unique case (op)
            OP_AND:   res = bus.a & bus.b;
            OP_OR:    res = bus.a | bus.b;
            OP_ADD:   res = bus.a + bus.b;
            OP_SRL:   res = bus.a >> shamt;
            OP_SRA:   res = $unsigned($signed(bus.a) >>> shamt);
            OP_SLL:   res = bus.a << shamt;
            OP_SUB:   res = bus.a - bus.b;
            OP_SLT:   res = {31'd0, lt};
            OP_XOR:   res = bus.a ^ bus.b;
            OP_SLTU:  res = {31'd0, ltu};
            OP_PASSB: res = bus.b;
            default:  res = 32'd0;
        endcase
    end

    // Evaluate the branch condition on the current operands.
    always_comb begin
        taken = 1'b0;
        unique case (br)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_BLT:  taken = lt;
            BR_BGE:  taken = !lt;
            BR_BLTU: taken = ltu;
            BR_BGEU: taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    assign alu_ctl_d = {br, op};
    assign alu_out_d = res;
    assign br_en_d   = taken;

    // Capture control word, result and branch flag together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_ctl_q <= 7'd0;
            alu_out_q <= 32'd0;
            br_en_q   <= 1'b0;
        end else begin
            alu_ctl_q <= alu_ctl_d;
            alu_out_q <= alu_out_d;
            br_en_q   <= br_en_d;
        end
    end

    assign bus.alu_ctl       = alu_ctl_q;
    assign bus.alu_out       = alu_out_q;
    assign bus.branch_enable = br_en_q;
endmodule

// File: tb/tb_alu_control.sv
// Directed-vector bench for alu_control.
// Expected values are hand-computed constants.
module tb_alu_control;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] LU = 7'b0110111;

    alu_control_if bus ();

    alu_control u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, obs, exp);
        end
    endtask

    // Apply inputs between edges, sample 1 time unit after next edge.
    task automatic apply(input logic [6:0]  opc,
                         input logic [3:0]  fc,
                         input logic [31:0] av,
                         input logic [31:0] bv);
        @(negedge clk);
        bus.opcode    = opc;
        bus.func_code = fc;
        bus.a         = av;
        bus.b         = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic run_out(input string tag,
                           input logic [6:0]  opc,
                           input logic [3:0]  fc,
                           input logic [31:0] av,
                           input logic [31:0] bv,
                           input logic [31:0] exp);
        apply(opc, fc, av, bv);
        check(tag, bus.alu_out, exp);
    endtask

    task automatic run_br(input string tag,
                          input logic [3:0]  fc,
                          input logic [31:0] av,
                          input logic [31:0] bv,
                          input logic        exp);
        apply(BR, fc, av, bv);
        check(tag, {31'd0, bus.branch_enable}, {31'd0, exp});
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset         = 1'b1;
        bus.opcode    = R;
        bus.func_code = 4'b0000;
        bus.a         = 32'd3;
        bus.b         = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", {25'd0, bus.alu_ctl}, 32'd0);
        check("rst_out", bus.alu_out, 32'd0);
        check("rst_br", {31'd0, bus.branch_enable}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_out("and", R, 4'b0111, 32'h0F, 32'h55, 32'h05);
        check("and_ctl", {25'd0, bus.alu_ctl}, 32'h00);
        run_out("or", R, 4'b0110, 32'h0F, 32'h55, 32'h5F);
        check("or_ctl", {25'd0, bus.alu_ctl}, 32'h01);
        run_out("add", R, 4'b0000, 32'd10000, 32'd111, 32'd10111);
        run_out("sub", R, 4'b1000, 32'd10000, 32'd111, 32'd9889);
        run_out("slt0", R, 4'b0010, 32'd0, 32'd2, 32'd1);
        run_out("srl", R, 4'b0101, 32'd16, 32'd2, 32'd4);
        run_out("sra", R, 4'b1101, 32'd8, 32'd1, 32'd4);
        run_out("sra_neg", R, 4'b1101, 32'h80000000, 32'd4,
                32'hF8000000);
        run_out("sll", R, 4'b0001, 32'd2, 32'd2, 32'd8);
        run_out("xor", R, 4'b0100, 32'h55, 32'hFF, 32'hAA);
        run_out("slt_s", R, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd1);
        run_out("sltu", R, 4'b0011, 32'hFFFFFFFF, 32'd1, 32'd0);
        run_out("add_wrap", R, 4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0);
        run_out("r_undef", R, 4'b1111, 32'd5, 32'd6, 32'd11);
        run_out("sll_bhi", R, 4'b0001, 32'd1, 32'hFFFFFFE3, 32'd8);

        run_out("i_sub_is_add", I, 4'b1000, 32'd7, 32'd3, 32'd10);
        run_out("i_srai", I, 4'b1101, 32'h80000000, 32'd4,
                32'hF8000000);
        run_out("i_srli", I, 4'b0101, 32'h80000000, 32'd4,
                32'h08000000);
        check("srli_ctl", {25'd0, bus.alu_ctl}, 32'h03);
        run_out("i_and", I, 4'b1111, 32'hF0, 32'h3C, 32'h30);
        run_out("load", LD, 4'b0010, 32'h1000, 32'h10, 32'h1010);
        run_out("lui", LU, 4'b0000, 32'h1234, 32'hABCD0000,
                32'hABCD0000);
        check("lui_ctl", {25'd0, bus.alu_ctl}, 32'h0A);

        run_br("beq", 4'b0000, 32'd5, 32'd5, 1'b1);
        check("beq_ctl", {25'd0, bus.alu_ctl}, 32'h16);
        check("beq_out", bus.alu_out, 32'd0);
        run_br("bne", 4'b0001, 32'd5, 32'd5, 1'b0);
        run_br("blt", 4'b0100, 32'hFFFFFFFF, 32'd1, 1'b1);
        run_br("bltu", 4'b0110, 32'hFFFFFFFF, 32'd1, 1'b0);
        run_br("bge", 4'b0101, 32'd1, 32'hFFFFFFFF, 1'b1);
        run_br("bgeu", 4'b0111, 32'hFFFFFFFF, 32'd1, 1'b1);
        run_br("br_f3_010", 4'b0010, 32'd5, 32'd5, 1'b0);
        check("f3_010_ctl", {25'd0, bus.alu_ctl}, 32'h06);
        run_br("bne_t", 4'b0001, 32'd4, 32'd5, 1'b1);

        run_out("pre_rst", R, 4'b0110, 32'h0F, 32'h55, 32'h5F);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_out", bus.alu_out, 32'd0);
        check("arst_ctl", {25'd0, bus.alu_ctl}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold", bus.alu_out, 32'd0);
        @(negedge clk);
        reset         = 1'b0;
        bus.opcode    = R;
        bus.func_code = 4'b0000;
        bus.a         = 32'd20;
        bus.b         = 32'd22;
        #1;
        check("post_rst0", bus.alu_out, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst1", bus.alu_out, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end
endmodule
